buffer_resp_checker: RTL and testbench
======================================

Name: buffer_resp_checker

Overview:
- Synthesizable response checker for the gate-level blocks; the receiving end of the stimulus path.
- Samples the stimulus driven into a gate under test and the gate's response.
- Aligns the two through a programmable latency delay line and compares them against the expected function: buffer (b = a) or inverter (b = ~a).
- Counts mismatches over a fixed sample window and reports pass/fail for on-chip or FPGA self-test.

Parameters:
- WIDTH, 1, bit width of the stimulus and response vectors.
- LATENCY, 0, cycles between a stimulus sample and its response. Legal range 0..15.
- NUM_SAMPLES, 4, number of compares per run. Must be ≥1.
- CNT_W, 8, width of the error and sample counters.
- INVERT, 0, 0 = expect a buffer, 1 = expect an inverter (expected value is ~a).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE or DONE.
- a_in  in  WIDTH  stimulus as driven into the gate under test.
- b_in  in  WIDTH  response from the gate under test.
- busy  out  1  high in FILL and CHECK.
- done  out  1  high in DONE; held until the next start or rst.
- pass  out  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  out  CNT_W  mismatching compares, saturating at all-ones.
- sample_cnt  out  CNT_W  compares performed in the current run.
- first_err_idx  out  CNT_W  sample_cnt value at the first mismatch; all-ones if there was none.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, pass=0, err_cnt=0, sample_cnt=0, first_err_idx=all-ones, delay line cleared to 0.
- All outputs are registered.
- States: IDLE, FILL, CHECK, DONE.
- IDLE/DONE, start=1:
  - clear err_cnt and sample_cnt; set first_err_idx=all-ones; done=0.
  - next state FILL if LATENCY>0, else CHECK.
- Delay line: LATENCY-deep shift register of a_in, shifting every cycle in every state. expected = tap[LATENCY], or a_in itself when LATENCY=0, XOR {WIDTH{INVERT}}.
- FILL: lasts exactly LATENCY cycles; no compares; then CHECK.
- CHECK, each cycle:
  - compare b_in against expected across all WIDTH bits; any differing bit counts as one mismatch.
  - sample_cnt increments.
  - on mismatch: err_cnt increments unless already all-ones. If first_err_idx is all-ones, capture the pre-increment sample_cnt into it.
  - when the compare numbered NUM_SAMPLES completes, next state is DONE.
- Timing: first compare uses the a_in presented on the start cycle +1 and b_in LATENCY cycles later. done rises (LATENCY + NUM_SAMPLES + 1) cycles after the start cycle.
- DONE: done=1, busy=0, pass=(err_cnt==0). Counters hold.
- start while busy: ignored; the run continues unaffected.
- start together with rst: rst wins; state=IDLE.
- rst in FILL or CHECK: abort to the reset values above; no done pulse.
- sample_cnt wrap: NUM_SAMPLES > 2^CNT_W-1 is illegal.
- Counter widths: all counters are exactly CNT_W bits, with no extension.

Optional Feature:
- Macro: BUF_CHK_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK moves to DONE the next cycle with err_cnt=1, pass=0, and sample_cnt = index+1. Remaining samples are skipped.
- Not defined: the full NUM_SAMPLES window always runs, and errors accumulate.

Test Plan:
- Clean buffer (WIDTH=1, LATENCY=0, INVERT=0, NUM_SAMPLES=4):
  - stimulus: b_in tied to a_in; a_in = 0,1,0,1; start pulse.
  - response: done rises 5 cycles after start; pass=1, err_cnt=0, sample_cnt=4, first_err_idx=8'hFF.
- Inverter mismatch:
  - stimulus: INVERT=0, b_in = ~a_in.
  - response: err_cnt=4, first_err_idx=0, pass=0.
  - with BUF_CHK_STOP_ON_ERR_EN: err_cnt=1, sample_cnt=1, done 2 cycles after start.
- Latency alignment:
  - stimulus: LATENCY=3; b_in is a_in delayed 3 flops; a_in toggles every cycle.
  - response: pass=1, done 8 cycles after start.
  - re-run with a 2-cycle delay: err_cnt=4.
- Single injected fault:
  - stimulus: WIDTH=4, b_in bit2 flipped on compare 2 only.
  - response: err_cnt=1, first_err_idx=2, pass=0.
- Control corner cases:
  - start pulsed mid-CHECK → ignored; counts unchanged.
  - rst asserted on compare 3 → busy=0, done=0, err_cnt=0 next cycle.
  - a new start after DONE clears done and reruns.
- Saturation:
  - stimulus: CNT_W=2, NUM_SAMPLES=3, all compares mismatch.
  - response: err_cnt=3 and no wrap to 0; pass=0.

Source files
------------

// File: rtl/buffer_resp_checker.sv
// buffer_resp_checker: receiving end of a gate self-test path.
// Samples the stimulus driven into a gate under test (a_in) and its response
// (b_in). Aligns them through a LATENCY-deep delay line and checks the
// response against a buffer (b = a) or inverter (b = ~a) function over a
// NUM_SAMPLES-compare window. Reports error count, first error index and
// pass/fail.
// Optional feature macro: BUF_CHK_STOP_ON_ERR_EN (stop the run at the first
// mismatch instead of completing the window).
//
// Handshake: start is a single-cycle request, accepted only when the FSM is in
// IDLE or DONE; it is dropped silently while busy. There is no ready/ack, so
// acceptance is visible as busy rising one clock later.
//
// Status outputs (busy/done/pass) are registered from the FSM state, so they
// trail the state register by one clock. done therefore rises
// LATENCY + NUM_SAMPLES + 1 clocks after the start cycle.
module buffer_resp_checker #(
  parameter int WIDTH       = 1,
  parameter int LATENCY     = 0,
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = 8,
  parameter int INVERT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ALL_ONES  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [3:0]       FILL_LAST = 4'(LATENCY - 1);
  localparam logic             INV_BIT   = (INVERT != 0);

  state_t           state;
  state_t           state_next;
  logic             start_ok;
  logic [3:0]       fill_cnt;
  logic [WIDTH-1:0] tap;
  logic [WIDTH-1:0] expected;
  logic             mismatch;

  // Delay line: tap is a_in as it was LATENCY clocks ago (or a_in itself).
  generate
    if (LATENCY == 0) begin : g_no_delay
      assign tap = a_in;
    end else begin : g_delay
      logic [WIDTH-1:0] dline [LATENCY];

      // Shift a_in through the line every cycle, independent of FSM state.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LATENCY; i++) dline[i] <= '0;
        end else begin
          dline[0] <= a_in;
          for (int i = 1; i < LATENCY; i++) dline[i] <= dline[i-1];
        end
      end

      assign tap = dline[LATENCY-1];
    end
  endgenerate

  assign expected  = tap ^ {WIDTH{INV_BIT}};
  assign mismatch  = (b_in != expected);
  assign state_dbg = state;

  // Next-state logic and start acceptance.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = (LATENCY > 0) ? FILL : CHECK;
        end
      end
      FILL: begin
        if (fill_cnt == FILL_LAST) state_next = CHECK;
      end
      CHECK: begin
        if (sample_cnt == LAST_IDX) state_next = DONE;
`ifdef BUF_CHK_STOP_ON_ERR_EN
        if (mismatch) state_next = DONE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fill_cnt      <= '0;
      err_cnt       <= '0;
      sample_cnt    <= '0;
      first_err_idx <= ALL_ONES;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= start_ok || (state == FILL) || (state == CHECK);
      done  <= (state == DONE) && !start_ok;
      pass  <= (state == DONE) && !start_ok && (err_cnt == '0);

      if (start_ok) begin
        fill_cnt      <= '0;
        err_cnt       <= '0;
        sample_cnt    <= '0;
        first_err_idx <= ALL_ONES;
      end

      if (state == FILL) fill_cnt <= fill_cnt + 4'd1;

      if (state == CHECK) begin
        sample_cnt <= sample_cnt + CNT_ONE;
        if (mismatch) begin
          if (err_cnt != ALL_ONES)       err_cnt       <= err_cnt + CNT_ONE;
          if (first_err_idx == ALL_ONES) first_err_idx <= sample_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_buffer_resp_checker.sv
// Bench for buffer_resp_checker: four checker instances with different
// parameter sets share one stimulus bus; a gate model builds b_in from the
// a_in history. Table-driven runs plus hand-written abort/restart sequences.
module tb_buffer_resp_checker;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] start_v;
  logic [3:0] a_in;
  logic [3:0] b_in;

  wire [3:0] busy_v;
  wire [3:0] done_v;
  wire [3:0] pass_v;
  wire [7:0] err_v  [4];
  wire [7:0] smp_v  [4];
  wire [7:0] fidx_v [4];
  wire [1:0] st_v   [4];
  wire [1:0] err2, smp2, fidx2;

  int n_checks = 0;
  int n_err    = 0;

  // Instance configuration as known to the bench.
  int lat_c  [4] = '{0, 3, 0, 1};
  int num_c  [4] = '{4, 4, 3, 5};
  int mask_c [4] = '{255, 255, 3, 255};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  buffer_resp_checker #(.WIDTH(4), .LATENCY(0), .NUM_SAMPLES(4), .CNT_W(8), .INVERT(0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_in(a_in), .b_in(b_in),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_cnt(err_v[0]), .sample_cnt(smp_v[0]), .first_err_idx(fidx_v[0]), .state_dbg(st_v[0]));

  buffer_resp_checker #(.WIDTH(4), .LATENCY(3), .NUM_SAMPLES(4), .CNT_W(8), .INVERT(0)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_in(a_in), .b_in(b_in),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_cnt(err_v[1]), .sample_cnt(smp_v[1]), .first_err_idx(fidx_v[1]), .state_dbg(st_v[1]));

  buffer_resp_checker #(.WIDTH(4), .LATENCY(0), .NUM_SAMPLES(3), .CNT_W(2), .INVERT(0)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a_in(a_in), .b_in(b_in),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_cnt(err2), .sample_cnt(smp2), .first_err_idx(fidx2), .state_dbg(st_v[2]));

  buffer_resp_checker #(.WIDTH(4), .LATENCY(1), .NUM_SAMPLES(5), .CNT_W(8), .INVERT(1)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .a_in(a_in), .b_in(b_in),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
    .err_cnt(err_v[3]), .sample_cnt(smp_v[3]), .first_err_idx(fidx_v[3]), .state_dbg(st_v[3]));

  assign err_v[2]  = {6'd0, err2};
  assign smp_v[2]  = {6'd0, smp2};
  assign fidx_v[2] = {6'd0, fidx2};

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    int         inst;     // which checker gets the start pulse
    int         dly;      // gate model delay in clocks
    bit         binv;     // gate model inverts
    bit         toggle;   // a_in alternates seed/~seed instead of random
    logic [3:0] seed;
    int         fcmp;     // 0-based compare whose response gets fmask flipped, -1 none
    logic [3:0] fmask;
    int         restart;  // cycle of an extra (ignored) start pulse, -1 none
    int         e_err;    // full-window error count
    int         e_first;  // first error index, -1 none
  } vec_t;

  typedef struct packed {
    logic [7:0] err;
    logic [7:0] smp;
    logic [7:0] fidx;
    logic       pass;
    logic [7:0] lat;
  } exp_t;

  exp_t       exp_q[$];
  vec_t       vecs[12];
  logic [3:0] hist[16];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus through the gate model.
  task automatic drive_cycle(input vec_t v, input int c, input logic [3:0] st);
    logic [3:0] na;
    logic [3:0] nb;
    if (v.toggle) na = (c % 2 == 1) ? ~v.seed : v.seed;
    else          na = 4'($urandom_range(0, 15));
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = na;
    nb = hist[v.dly] ^ (v.binv ? 4'hF : 4'h0);
    if (v.fcmp >= 0 && c == lat_c[v.inst] + v.fcmp + 1) nb = nb ^ v.fmask;
    a_in    = na;
    b_in    = nb;
    start_v = st;
  endtask

  function automatic exp_t build_exp(input vec_t v);
    exp_t e;
    int   n;
    int   l;
    n = num_c[v.inst];
    l = lat_c[v.inst];
    e.fidx = (v.e_first < 0) ? 8'(mask_c[v.inst]) : 8'(v.e_first);
    e.err  = 8'(v.e_err);
    e.smp  = 8'(n);
    e.lat  = 8'(l + n + 1);
`ifdef BUF_CHK_STOP_ON_ERR_EN
    if (v.e_first >= 0) begin
      e.err = 8'd1;
      e.smp = 8'(v.e_first + 1);
      e.lat = 8'(l + v.e_first + 2);
    end
`endif
    e.pass = (e.err == 8'd0);
    return e;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    exp_t       e;
    bit         seen;
    logic [3:0] st;
    int         i;
    i = v.inst;
    exp_q.push_back(build_exp(v));
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      st = 4'd0;
      if (c == 0 || c == v.restart) st[i] = 1'b1;
      drive_cycle(v, c, st);
      @(posedge clk); #1;
      if (c == 0) begin
        check($sformatf("v%0d_busy_after_start", id), int'(busy_v[i]), 1);
        check($sformatf("v%0d_done_cleared", id), int'(done_v[i]), 0);
      end
      if (done_v[i]) begin
        seen = 1;
        e = exp_q.pop_front();
        check($sformatf("v%0d_latency", id), c, int'(e.lat));
        check($sformatf("v%0d_err_cnt", id), int'(err_v[i]), int'(e.err));
        check($sformatf("v%0d_sample_cnt", id), int'(smp_v[i]), int'(e.smp));
        check($sformatf("v%0d_first_err_idx", id), int'(fidx_v[i]), int'(e.fidx));
        check($sformatf("v%0d_pass", id), int'(pass_v[i]), int'(e.pass));
        check($sformatf("v%0d_busy_at_done", id), int'(busy_v[i]), 0);
        // done and counters hold while idle in DONE
        for (int h = 0; h < 2; h++) begin
          drive_cycle(v, c + 1 + h, 4'd0);
          @(posedge clk); #1;
        end
        check($sformatf("v%0d_done_hold", id), int'(done_v[i]), 1);
        check($sformatf("v%0d_err_hold", id), int'(err_v[i]), int'(e.err));
      end
    end
    start_v = 4'd0;
    if (!seen) begin
      e = exp_q.pop_front();
      check($sformatf("v%0d_done_timeout", id), 0, 1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    //            inst dly binv tog seed  fcmp fmask restart err first
    vecs[0]  = '{0, 0, 1'b0, 1'b1, 4'h0, -1, 4'h0, -1, 0, -1};  // clean buffer 0,F,0,F
    vecs[1]  = '{0, 0, 1'b1, 1'b0, 4'h0, -1, 4'h0, -1, 4, 0};   // inverter into buffer check
    vecs[2]  = '{0, 0, 1'b0, 1'b0, 4'h0, 2,  4'h4, -1, 1, 2};   // bit2 flipped on compare 2
    vecs[3]  = '{0, 0, 1'b0, 1'b0, 4'h0, 2,  4'h4, 2,  1, 2};   // start mid-CHECK ignored
    vecs[4]  = '{1, 3, 1'b0, 1'b1, 4'h5, -1, 4'h0, -1, 0, -1};  // latency 3 aligned
    vecs[5]  = '{1, 2, 1'b0, 1'b1, 4'h5, -1, 4'h0, -1, 4, 0};   // gate delay 2 vs latency 3
    vecs[6]  = '{1, 3, 1'b0, 1'b0, 4'h0, 0,  4'h8, -1, 1, 0};   // fault on first compare
    vecs[7]  = '{2, 0, 1'b1, 1'b0, 4'h0, -1, 4'h0, -1, 3, 0};   // 2-bit counters, all mismatch
    vecs[8]  = '{3, 1, 1'b1, 1'b0, 4'h0, -1, 4'h0, -1, 0, -1};  // clean inverter
    vecs[9]  = '{3, 1, 1'b0, 1'b0, 4'h0, -1, 4'h0, -1, 5, 0};   // buffer into inverter check
    vecs[10] = '{3, 1, 1'b1, 1'b0, 4'h0, 4,  4'h1, -1, 1, 4};   // fault on last compare
    vecs[11] = '{0, 0, 1'b0, 1'b0, 4'h0, 3,  4'h1, -1, 1, 3};   // fault on last compare

    for (int k = 0; k < 16; k++) hist[k] = 4'h0;

    // reset block
    rst     = 1'b1;
    start_v = 4'd0;
    a_in    = 4'h0;
    b_in    = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst%0d_busy", i), int'(busy_v[i]), 0);
      check($sformatf("rst%0d_done", i), int'(done_v[i]), 0);
      check($sformatf("rst%0d_pass", i), int'(pass_v[i]), 0);
      check($sformatf("rst%0d_err", i), int'(err_v[i]), 0);
      check($sformatf("rst%0d_smp", i), int'(smp_v[i]), 0);
      check($sformatf("rst%0d_fidx", i), int'(fidx_v[i]), mask_c[i]);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // table-driven runs
    for (int k = 0; k < 12; k++) run_vec(vecs[k], k);

    // abort: rst (with a simultaneous start) on compare 3 of a failing run
    v = vecs[1];
    for (int c = 0; c < 3; c++) begin
      drive_cycle(v, c, (c == 0) ? 4'b0001 : 4'b0000);
      @(posedge clk); #1;
    end
    check("abort_err_before_rst", int'(err_v[0]), 2);
    drive_cycle(v, 3, 4'b0001);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", int'(busy_v[0]), 0);
    check("abort_done", int'(done_v[0]), 0);
    check("abort_err", int'(err_v[0]), 0);
    check("abort_smp", int'(smp_v[0]), 0);
    check("abort_fidx", int'(fidx_v[0]), 255);
    begin
      int done_seen;
      done_seen = 0;
      for (int c = 4; c < 12; c++) begin
        drive_cycle(v, c, 4'd0);
        @(posedge clk); #1;
        if (done_v[0] || busy_v[0]) done_seen = 1;
      end
      check("abort_no_done_pulse", done_seen, 0);
    end

    // fresh run after the abort
    run_vec(vecs[0], 12);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
